amo_responder: RTL

AMO_RESPONDER -- requirements
Module: amo_responder

---
 rtl/ariane_pkg.sv | 35 +++
 rtl/riscv.sv | 5 +
 rtl/amo_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// ariane_pkg: AMO request/response types used between the issuing pipeline
// and the AMO responder.
//   amo_t      - atomic operation code
//   amo_req_t  - req, amo_op, size (2'b10 word, 2'b11 double), operand_a
//                (physical address), operand_b (store data)
//   amo_resp_t - ack (single-cycle pulse), result (64-bit)
package ariane_pkg;
  typedef enum logic [3:0] {
    AMO_NONE,
    AMO_LR,
    AMO_SC,
    AMO_SWAP,
    AMO_ADD,
    AMO_AND,
    AMO_OR,
    AMO_XOR,
    AMO_MAX,
    AMO_MAXU,
    AMO_MIN,
    AMO_MINU
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;
endpackage

// File: rtl/riscv.sv
// riscv: architectural constants shared with the memory path.
//   PLEN - physical address width in bits.
package riscv;
  localparam int unsigned PLEN = 56;
endpackage

// File: rtl/amo_responder.sv
// amo_responder: executes one RISC-V atomic memory operation at a time as a
// read-modify-write sequence on a 64-bit memory port.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   amo_req_i            AMO request (held stable by the initiator until ack)
//   amo_resp_o           ack pulse plus 64-bit result (old value / SC status)
//   mem_req_o, mem_we_o  memory request valid, write enable
//   mem_addr_o           8-byte-aligned physical address
//   mem_wdata_o          lane-aligned write data
//   mem_be_o             byte enables (8'h0F / 8'hF0 word, 8'hFF double)
//   mem_gnt_i            memory accepted the request this cycle
//   mem_rvalid_i         read data valid
//   mem_rdata_i          read data
//   resv_clr_i           external invalidation of the LR reservation
//
// Build option: define AMO_RESPONDER_LRSC_EN to keep an LR reservation so SC
// can succeed. Without it LR is a plain read and every SC fails.
module amo_responder #(
  parameter int unsigned AddrWidth = riscv::PLEN
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ariane_pkg::amo_req_t  amo_req_i,
  output ariane_pkg::amo_resp_t amo_resp_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AddrWidth-1:0]  mem_addr_o,
  output logic [63:0]           mem_wdata_o,
  output logic [7:0]            mem_be_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [63:0]           mem_rdata_i,
  input  logic                  resv_clr_i
);
  import ariane_pkg::*;

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_e;

  state_e      state;
  amo_t        op_q;
  logic        word_q;
  logic        lane_q;
  logic [63:0] operand_q;

  // Request decode (used only on the IDLE transition)
  logic                 req_word;
  logic                 req_legal;
  logic [AddrWidth-1:0] req_addr;
  logic [7:0]           req_be;
  logic [63:0]          req_wdata;
  logic                 sc_ok;
  logic [63:0]          unused_opa;

  assign req_word   = (amo_req_i.size == 2'b10);
  assign req_legal  = amo_req_i.size[1];
  assign req_addr   = {amo_req_i.operand_a[AddrWidth-1:3], 3'b000};
  assign req_be     = req_word ? (amo_req_i.operand_a[2] ? 8'hF0 : 8'h0F) : 8'hFF;
  assign req_wdata  = req_word ? {2{amo_req_i.operand_b[31:0]}} : amo_req_i.operand_b;
  assign unused_opa = amo_req_i.operand_a;

`ifdef AMO_RESPONDER_LRSC_EN
  logic                 resv_valid;
  logic [AddrWidth-1:0] resv_addr;
  assign sc_ok = resv_valid && (resv_addr == req_addr);
`else
  logic unused_resv_clr;
  assign unused_resv_clr = resv_clr_i;
  assign sc_ok = 1'b0;
`endif

  // Read-modify-write datapath, evaluated from the latched operation and the
  // returning read data. Word ops build sign- and zero-extended 64-bit views
  // so one comparator set serves both widths.
  logic [31:0] old32;
  logic [63:0] a_sx, a_zx, b_sx, b_zx;
  logic [63:0] new_val;
  logic [63:0] new_wdata;
  logic [7:0]  cur_be;
  logic        needs_write;

  always_comb begin
    old32 = lane_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    a_sx  = word_q ? {{32{old32[31]}}, old32} : mem_rdata_i;
    a_zx  = word_q ? {32'h0, old32} : mem_rdata_i;
    b_sx  = word_q ? {{32{operand_q[31]}}, operand_q[31:0]} : operand_q;
    b_zx  = word_q ? {32'h0, operand_q[31:0]} : operand_q;
    case (op_q)
      AMO_SWAP: new_val = b_zx;
      AMO_ADD:  new_val = a_zx + b_zx;
      AMO_AND:  new_val = a_zx & b_zx;
      AMO_OR:   new_val = a_zx | b_zx;
      AMO_XOR:  new_val = a_zx ^ b_zx;
      AMO_MAX:  new_val = ($signed(a_sx) > $signed(b_sx)) ? a_sx : b_sx;
      AMO_MIN:  new_val = ($signed(a_sx) < $signed(b_sx)) ? a_sx : b_sx;
      AMO_MAXU: new_val = (a_zx > b_zx) ? a_zx : b_zx;
      AMO_MINU: new_val = (a_zx < b_zx) ? a_zx : b_zx;
      default:  new_val = a_zx;
    endcase
    new_wdata   = word_q ? {2{new_val[31:0]}} : new_val;
    cur_be      = word_q ? (lane_q ? 8'hF0 : 8'h0F) : 8'hFF;
    needs_write = op_q inside {AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR, AMO_XOR,
                               AMO_MAX, AMO_MIN, AMO_MAXU, AMO_MINU};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      op_q              <= AMO_NONE;
      word_q            <= 1'b0;
      lane_q            <= 1'b0;
      operand_q         <= '0;
      mem_req_o         <= 1'b0;
      mem_we_o          <= 1'b0;
      mem_be_o          <= '0;
      mem_addr_o        <= '0;
      mem_wdata_o       <= '0;
      amo_resp_o.ack    <= 1'b0;
      amo_resp_o.result <= '0;
`ifdef AMO_RESPONDER_LRSC_EN
      resv_valid        <= 1'b0;
      resv_addr         <= '0;
`endif
    end else begin
`ifdef AMO_RESPONDER_LRSC_EN
      // An LR accepted in the same cycle overrides this below.
      if (resv_clr_i) resv_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          amo_resp_o.ack <= 1'b0;
          if (amo_req_i.req && amo_req_i.amo_op != AMO_NONE) begin
            op_q       <= amo_req_i.amo_op;
            word_q     <= req_word;
            lane_q     <= amo_req_i.operand_a[2];
            operand_q  <= amo_req_i.operand_b;
            mem_addr_o <= req_addr;
            if (!req_legal) begin
              state             <= RESP;
              amo_resp_o.ack    <= 1'b1;
              amo_resp_o.result <= '0;
            end else if (amo_req_i.amo_op == AMO_SC) begin
`ifdef AMO_RESPONDER_LRSC_EN
              resv_valid <= 1'b0;
`endif
              if (sc_ok) begin
                state       <= WR;
                mem_req_o   <= 1'b1;
                mem_we_o    <= 1'b1;
                mem_be_o    <= req_be;
                mem_wdata_o <= req_wdata;
              end else begin
                state             <= RESP;
                amo_resp_o.ack    <= 1'b1;
                amo_resp_o.result <= 64'd1;
              end
            end else begin
              state     <= RD;
              mem_req_o <= 1'b1;
              mem_we_o  <= 1'b0;
              mem_be_o  <= req_be;
`ifdef AMO_RESPONDER_LRSC_EN
              if (amo_req_i.amo_op == AMO_LR) begin
                resv_valid <= 1'b1;
                resv_addr  <= req_addr;
              end
`endif
            end
          end
        end
        RD: begin
          if (mem_gnt_i) begin
            state     <= RD_WAIT;
            mem_req_o <= 1'b0;
            mem_be_o  <= '0;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            amo_resp_o.result <= a_sx;
            if (needs_write) begin
              state       <= WR;
              mem_req_o   <= 1'b1;
              mem_we_o    <= 1'b1;
              mem_be_o    <= cur_be;
              mem_wdata_o <= new_wdata;
            end else begin
              state          <= RESP;
              amo_resp_o.ack <= 1'b1;
            end
          end
        end
        WR: begin
          if (mem_gnt_i) begin
            state          <= RESP;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_be_o       <= '0;
            amo_resp_o.ack <= 1'b1;
            if (op_q == AMO_SC) amo_resp_o.result <= '0;
`ifdef AMO_RESPONDER_LRSC_EN
            if (resv_addr == mem_addr_o) resv_valid <= 1'b0;
`endif
          end
        end
        RESP: begin
          amo_resp_o.ack <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
